// File: rtl/ws2812b_pkg.sv
// Shared pixel width, default WS2812B timing (100 MHz clock) and FSM encoding.
package ws2812b_pkg;
  localparam int PIX_W        = 24;
  localparam int DEF_NUM_LEDS = 3;
  localparam int DEF_T0H_CYC  = 40;
  localparam int DEF_T1H_CYC  = 80;
  localparam int DEF_BIT_CYC  = 125;
  localparam int DEF_RES_CYC  = 5000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ws2812b_bit_enc.sv
// One WS2812B bit: a one-cycle load starts a BIT_CYC period that is high for
// T1H_CYC/T0H_CYC cycles; bit_done_o marks the last cycle so the next load can abut it.
module ws2812b_bit_enc
  import ws2812b_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic bit_i,
  output logic bit_o,
  output logic bit_done_o
);
  localparam int            CW   = cnt_w(BIT_CYC);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  localparam logic [CW:0]   HI0  = (CW+1)'(T0H_CYC);
  localparam logic [CW:0]   HI1  = (CW+1)'(T1H_CYC);

  logic          r_active;
  logic          r_val;
  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_hi;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active <= 1'b0;
      r_val    <= 1'b0;
      r_cnt    <= '0;
    end else if (load_i) begin
      r_active <= 1'b1;
      r_val    <= bit_i;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (r_cnt == LAST) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Compare one bit wider so a high time equal to the full period still fits.
  assign w_hi       = r_val ? HI1 : HI0;
  assign bit_o      = r_active & ({1'b0, r_cnt} < w_hi);
  assign bit_done_o = r_active & (r_cnt == LAST);
endmodule

// File: rtl/ws2812b_frame_ctrl.sv
// WS2812B frame controller: fetches NUM_LEDS GRB pixels over valid/ready with a
// one-entry prefetch, streams them MSB first without gaps, then holds the reset latch.
module ws2812b_frame_ctrl
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int BIT_CYC  = DEF_BIT_CYC,
  parameter int RES_CYC  = DEF_RES_CYC
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         pix_valid_i,
  input  logic [PIX_W-1:0]             pix_data_i,
  output logic                         pix_ready_o,
  output logic [cnt_w(NUM_LEDS)-1:0]   pix_idx_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         underrun_o,
  output logic                         bit_o
);
  localparam int               IDX_W    = cnt_w(NUM_LEDS);
  localparam int               NXF_W    = cnt_w(NUM_LEDS + 1);
  localparam int               LAT_W    = cnt_w(RES_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [NXF_W-1:0] NXF_ALL  = NXF_W'(NUM_LEDS);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RES_CYC - 1);
  localparam logic [4:0]       BIT_LAST = 5'(PIX_W - 1);

  state_t             r_state, w_state_nxt;
  logic [PIX_W-2:0]   r_rest;
  logic [PIX_W-1:0]   r_hold;
  logic               r_hold_vld;
  logic [4:0]         r_bit_idx;
  logic [IDX_W-1:0]   r_idx;
  logic [NXF_W-1:0]   r_nxf;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               w_more, w_xfer, w_last_bit, w_bit_done;
  logic               w_enc_load, w_enc_bit;

  assign w_more     = (r_nxf != NXF_ALL);
  assign w_xfer     = pix_valid_i & pix_ready_o;
  assign w_last_bit = (r_bit_idx == BIT_LAST);
  assign busy_o     = (r_state != ST_IDLE);
  assign pix_idx_o  = r_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    pix_ready_o = 1'b0;
    w_enc_load  = 1'b0;
    w_enc_bit   = 1'b0;
    done_o      = 1'b0;
    underrun_o  = 1'b0;
    case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        pix_ready_o = 1'b1;
        if (pix_valid_i) begin
          w_enc_load  = 1'b1;
          w_enc_bit   = pix_data_i[PIX_W-1];
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        pix_ready_o = ~r_hold_vld & w_more;
        if (w_bit_done) begin
          if (!w_last_bit) begin
            w_enc_load = 1'b1;
            w_enc_bit  = r_rest[PIX_W-2];
          end else if (r_hold_vld) begin
            w_enc_load = 1'b1;
            w_enc_bit  = r_hold[PIX_W-1];
          end else if (w_xfer) begin
            // A pixel arriving exactly at the boundary goes straight to the wire.
            w_enc_load = 1'b1;
            w_enc_bit  = pix_data_i[PIX_W-1];
          end else begin
            underrun_o  = w_more;
            w_state_nxt = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (r_lat_cnt == LAT_LAST) begin
          done_o      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rest     <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_bit_idx  <= '0;
      r_idx      <= '0;
      r_nxf      <= '0;
      r_lat_cnt  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start_i) begin
        r_idx      <= '0;
        r_nxf      <= '0;
        r_hold_vld <= 1'b0;
      end
      if (w_xfer) begin
        r_nxf <= r_nxf + NXF_W'(1);
        if (r_idx != IDX_LAST) r_idx <= r_idx + IDX_W'(1);
      end
      if ((r_state == ST_FETCH) && w_xfer) begin
        r_rest    <= pix_data_i[PIX_W-2:0];
        r_bit_idx <= '0;
      end else if ((r_state == ST_SEND) && w_bit_done) begin
        if (!w_last_bit) begin
          r_rest    <= {r_rest[PIX_W-3:0], 1'b0};
          r_bit_idx <= r_bit_idx + 5'd1;
        end else if (r_hold_vld) begin
          r_rest     <= r_hold[PIX_W-2:0];
          r_bit_idx  <= '0;
          r_hold_vld <= 1'b0;
        end else if (w_xfer) begin
          r_rest    <= pix_data_i[PIX_W-2:0];
          r_bit_idx <= '0;
        end
      end
      if ((r_state == ST_SEND) && w_xfer && !(w_bit_done && w_last_bit)) begin
        r_hold     <= pix_data_i;
        r_hold_vld <= 1'b1;
      end
      if (r_state == ST_LATCH) r_lat_cnt <= (r_lat_cnt == LAT_LAST) ? '0 : r_lat_cnt + LAT_W'(1);
      else                     r_lat_cnt <= '0;
    end
  end

  ws2812b_bit_enc #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_enc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_enc_load),
    .bit_i      (w_enc_bit),
    .bit_o      (bit_o),
    .bit_done_o (w_bit_done)
  );
endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Frame-level bench: table of frame scenarios checked against a waveform model
// built from pixel bits and WS2812B timing, plus reset and restart sequences.
module tb_ws2812b_frame_ctrl;
  localparam int T0H  = 40;
  localparam int T1H  = 80;
  localparam int BITC = 125;
  localparam int RES  = 5000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        pix_valid_i;
  logic [23:0] pix_data_i;
  logic        pix_ready_o;
  logic [1:0]  pix_idx_o;
  logic        busy_o, done_o, underrun_o, bit_o;

  ws2812b_frame_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .pix_valid_i (pix_valid_i),
    .pix_data_i  (pix_data_i),
    .pix_ready_o (pix_ready_o),
    .pix_idx_o   (pix_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .underrun_o  (underrun_o),
    .bit_o       (bit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [23:0] p0, p1, p2;
    int gap0, gap1, gap2;   // idle cycles before offering each pixel
    int s0, s1;             // extra start_i pulses (sample index), -1 = none
    int n_sent;
    bit under;
    int exp_ones;           // '1' bits on the wire, -1 = count from pixels
    int exp_done;           // sample index of done_o, -1 = take from model
    int exp_idx;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic obs_bit[$];
  logic obs_busy[$];
  logic exp_bit[$];
  int   done_q[$];
  int   und_q[$];
  int   m_done;
  logic [1:0] idx0, idx_end;
  vec_t vecs[4];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference waveform: t0 idle samples, 24 bits per pixel MSB first, then the latch.
  task automatic build_model(input logic [2:0][23:0] px, input int n_sent, input int t0);
    int hi;
    exp_bit.delete();
    for (int i = 0; i < t0; i++) exp_bit.push_back(1'b0);
    for (int p = 0; p < n_sent; p++)
      for (int b = 23; b >= 0; b--) begin
        hi = px[p][b] ? T1H : T0H;
        for (int c = 0; c < BITC; c++) exp_bit.push_back(c < hi);
      end
    for (int c = 0; c < RES; c++) exp_bit.push_back(1'b0);
    m_done = exp_bit.size() - 1;
  endtask

  task automatic drive_frame(input logic [2:0][23:0] px, input int g0, input int g1, input int g2,
                             input int s0, input int s1, input int n_iter);
    int gap[3];
    int k;
    int wait_c;
    gap[0] = g0; gap[1] = g1; gap[2] = g2;
    k = 0; wait_c = g0;
    obs_bit.delete(); obs_busy.delete(); done_q.delete(); und_q.delete();
    @(negedge clk_i);
    start_i = 1'b1;
    pix_valid_i = 1'b0;
    for (int i = 0; i < n_iter; i++) begin
      @(negedge clk_i);
      start_i = (i == s0) || (i == s1);
      if (k < 3) begin
        if (wait_c > 0) begin
          pix_valid_i = 1'b0;
          wait_c--;
        end else begin
          pix_valid_i = 1'b1;
          pix_data_i  = px[k];
          if (pix_ready_o) begin
            k++;
            if (k < 3) wait_c = gap[k];
          end
        end
      end else begin
        pix_valid_i = 1'b0;
      end
      #1;
      obs_bit.push_back(bit_o);
      obs_busy.push_back(busy_o);
      if (done_o) done_q.push_back(i);
      if (underrun_o) und_q.push_back(i);
      if (i == 0) idx0 = pix_idx_o;
    end
    idx_end = pix_idx_o;
    start_i = 1'b0;
    pix_valid_i = 1'b0;
  endtask

  task automatic compare_wave(input string name, input int n);
    int mism = 0;
    int first = -1;
    for (int i = 0; i < n && i < exp_bit.size(); i++)
      if (i >= obs_bit.size() || obs_bit[i] !== exp_bit[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    check($sformatf("%s bit_o bad samples (first at %0d)", name, first), mism, 0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [2:0][23:0] px;
    string nm;
    int t0, ones, exp_ones, hi, fr, bmis;
    nm = $sformatf("vec%0d", n);
    px = {v.p2, v.p1, v.p0};
    t0 = v.gap0 + 1;
    build_model(px, v.n_sent, t0);
    drive_frame(px, v.gap0, v.gap1, v.gap2, v.s0, v.s1, exp_bit.size() + 30);

    compare_wave(nm, exp_bit.size());
    bmis = 0;
    for (int i = 0; i < obs_busy.size(); i++) if (obs_busy[i] !== (i <= m_done)) bmis++;
    check({nm, " busy_o bad samples"}, bmis, 0);
    check({nm, " done_o pulses"}, done_q.size(), 1);
    check({nm, " done_o sample"}, (done_q.size() > 0) ? done_q[0] : -1,
          (v.exp_done >= 0) ? v.exp_done : m_done);
    check({nm, " underrun_o pulses"}, und_q.size(), v.under);
    check({nm, " underrun_o sample"}, (und_q.size() > 0) ? und_q[0] : -1,
          v.under ? (t0 + v.n_sent * 24 * BITC - 1) : -1);
    fr = -1;
    for (int i = 0; i < obs_bit.size(); i++) if (obs_bit[i] === 1'b1 && fr < 0) fr = i;
    check({nm, " first rise sample"}, fr, t0);
    ones = 0;
    for (int j = 0; j < v.n_sent * 24; j++) begin
      hi = 0;
      for (int c = 0; c < BITC; c++)
        if (t0 + j * BITC + c < obs_bit.size() && obs_bit[t0 + j * BITC + c] === 1'b1) hi++;
      if (hi == T1H) ones++;
    end
    exp_ones = v.exp_ones;
    if (exp_ones < 0) begin
      exp_ones = 0;
      for (int p = 0; p < v.n_sent; p++) exp_ones += $countones(px[p]);
    end
    check({nm, " bits with 80-cycle high"}, ones, exp_ones);
    check({nm, " pix_idx_o at start"}, idx0, 0);
    check({nm, " pix_idx_o at end"}, idx_end, v.exp_idx);
  endtask

  initial begin
    int cnt_done, cnt_busy;
    rst_ni = 1'b0; start_i = 1'b0; pix_valid_i = 1'b0; pix_data_i = '0;

    vecs[0] = '{p0:24'hFF0000, p1:24'h00FF00, p2:24'h0000FF, gap0:0, gap1:0, gap2:0,
                s0:1000, s1:9500, n_sent:3, under:1'b0, exp_ones:24, exp_done:14000, exp_idx:2};
    vecs[1] = '{p0:24'hAAAAAA, p1:24'hAAAAAA, p2:24'hAAAAAA, gap0:10, gap1:5, gap2:7,
                s0:-1, s1:14010, n_sent:3, under:1'b0, exp_ones:36, exp_done:14010, exp_idx:2};
    vecs[2] = '{p0:24'h123456, p1:24'h654321, p2:24'hABCDEF, gap0:0, gap1:3100, gap2:0,
                s0:-1, s1:-1, n_sent:1, under:1'b1, exp_ones:9, exp_done:8000, exp_idx:1};
    vecs[3] = '{p0:24'($urandom), p1:24'($urandom), p2:24'($urandom),
                gap0:$urandom_range(0, 20), gap1:$urandom_range(0, 200), gap2:$urandom_range(0, 200),
                s0:-1, s1:-1, n_sent:3, under:1'b0, exp_ones:-1, exp_done:-1, exp_idx:2};

    repeat (3) @(negedge clk_i);
    #1;
    check("reset bit_o", bit_o, 0);
    check("reset pix_ready_o", pix_ready_o, 0);
    check("reset busy_o", busy_o, 0);
    check("reset done_o", done_o, 0);
    check("reset underrun_o", underrun_o, 0);
    check("reset pix_idx_o", pix_idx_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int n = 0; n < 4; n++) run_vec(n, vecs[n]);

    // Reset in SEND cycle 500 while a '1' bit is high.
    drive_frame({3{24'hFFFFFF}}, 0, 0, 0, -1, -1, 502);
    check("midframe bit_o before reset", obs_bit[501], 1);
    rst_ni = 1'b0;
    #1;
    check("midframe bit_o in reset", bit_o, 0);
    check("midframe busy_o in reset", busy_o, 0);
    check("midframe pix_ready_o in reset", pix_ready_o, 0);
    check("midframe pix_idx_o in reset", pix_idx_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #1;
      if (done_o) cnt_done++;
      if (busy_o) cnt_busy++;
    end
    check("after reset done_o pulses", cnt_done, 0);
    check("after reset busy_o cycles", cnt_busy, 0);

    build_model({24'h000000, 24'h000000, 24'h5A0000}, 3, 3);
    drive_frame({24'h000000, 24'h000000, 24'h5A0000}, 2, 0, 0, -1, -1, 400);
    check("restart pix_idx_o at start", idx0, 0);
    compare_wave("restart", 400);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
